// File: rtl/settings_bus_arb.sv
// rtl/settings_bus_arb.sv - Round-robin arbiter from N masters onto a single settings bus with optional readback
//
// Ports:
//   clk, reset_n      clock (rising edge) and asynchronous active-low reset
//   in_stb/addr/data  per-port requests; port i packed at [i*W +: W]
//   in_ready          one-hot (or zero) accept, combinational, only in IDLE
//   resp_stb          one-cycle completion pulse to the granted port
//   resp_data         readback data (all ones on timeout, 0 when RB_EN=0)
//   resp_timeout      qualifies resp_stb: readback wait expired
//   set_stb/addr/data settings bus write; addr/data forced to 0 when idle
//   rb_stb, rb_data   slave readback, sampled only while waiting for it
module settings_bus_arb #(
    parameter int AWIDTH    = 8,
    parameter int DWIDTH    = 32,
    parameter int RBWIDTH   = 64,
    parameter int NUM_PORTS = 4,
    parameter int RB_EN     = 1,
    parameter int TIMEOUT   = 255
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NUM_PORTS-1:0]          in_stb,
    input  logic [NUM_PORTS*AWIDTH-1:0]   in_addr,
    input  logic [NUM_PORTS*DWIDTH-1:0]   in_data,
    output logic [NUM_PORTS-1:0]          in_ready,
    output logic [NUM_PORTS-1:0]          resp_stb,
    output logic [RBWIDTH-1:0]            resp_data,
    output logic                          resp_timeout,
    output logic                          set_stb,
    output logic [AWIDTH-1:0]             set_addr,
    output logic [DWIDTH-1:0]             set_data,
    input  logic                          rb_stb,
    input  logic [RBWIDTH-1:0]            rb_data
);

    localparam int IW = $clog2(NUM_PORTS);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RB, RESPOND} state_t;

    state_t                state;
    logic [IW-1:0]         last_grant;
    logic [IW-1:0]         grant;
    logic [IW-1:0]         pick;
    logic [IW-1:0]         cand;
    logic                  pick_vld;
    logic [15:0]           count;
    logic [NUM_PORTS-1:0]  pick_oh;
    logic [NUM_PORTS-1:0]  grant_oh;

    // Round-robin search: first requester after last_grant, wrapping modulo NUM_PORTS
    // (NUM_PORTS need not be a power of two, so the wrap is explicit).
    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
        cand     = '0;
        for (int k = 1; k <= NUM_PORTS; k++) begin
            cand = IW'((int'(last_grant) + k) % NUM_PORTS);
            if (!pick_vld && in_stb[cand]) begin
                pick_vld = 1'b1;
                pick     = cand;
            end
        end
    end

    assign pick_oh  = {{(NUM_PORTS-1){1'b0}}, 1'b1} << pick;
    assign grant_oh = {{(NUM_PORTS-1){1'b0}}, 1'b1} << grant;

    // Gated by reset_n so the accept is withdrawn the instant reset asserts.
    assign in_ready = (reset_n && state == IDLE && pick_vld) ? pick_oh : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            last_grant   <= IW'(NUM_PORTS - 1);
            grant        <= '0;
            count        <= '0;
            set_stb      <= 1'b0;
            set_addr     <= '0;
            set_data     <= '0;
            resp_stb     <= '0;
            resp_data    <= '0;
            resp_timeout <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        // Request fields go straight into the bus registers so
                        // set_stb/addr/data appear together in the ISSUE cycle.
                        grant      <= pick;
                        last_grant <= pick;
                        set_stb    <= 1'b1;
                        set_addr   <= in_addr[int'(pick)*AWIDTH +: AWIDTH];
                        set_data   <= in_data[int'(pick)*DWIDTH +: DWIDTH];
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    set_stb  <= 1'b0;
                    set_addr <= '0;
                    set_data <= '0;
                    if (RB_EN != 0) begin
                        count <= '0;
                        state <= WAIT_RB;
                    end else begin
                        resp_stb     <= grant_oh;
                        resp_data    <= '0;
                        resp_timeout <= 1'b0;
                        state        <= RESPOND;
                    end
                end
                WAIT_RB: begin
                    // rb_stb is tested first so it wins over a coinciding timeout.
                    if (rb_stb) begin
                        resp_stb     <= grant_oh;
                        resp_data    <= rb_data;
                        resp_timeout <= 1'b0;
                        state        <= RESPOND;
                    end else if (count == 16'(TIMEOUT - 1)) begin
                        resp_stb     <= grant_oh;
                        resp_data    <= '1;
                        resp_timeout <= 1'b1;
                        state        <= RESPOND;
                    end else begin
                        count <= count + 16'd1;
                    end
                end
                RESPOND: begin
                    // resp_data/resp_timeout are left alone until the next response.
                    resp_stb <= '0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
